// File: rtl/split_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : split_reg_pkg
// Description : Shared types, defaults and field-width helpers for split_reg.
// Revision    : 1.0
// ============================================================================
package split_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    function automatic int sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

    // Request word is {valid, address, wdata, wstrb}, MSB first.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response word is {rdata, ready}, ready in bit 0.
    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/split_timer.sv
`default_nettype none
// ============================================================================
// Module      : split_timer
// Description : Up-counter that flags expiry on its TIMEOUT-th enabled cycle.
// Revision    : 1.0
// ============================================================================
module split_timer
    import split_reg_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is qualified by enable so a same-cycle ready always wins.
    generate
        if (TIMEOUT > 0) begin : g_timeout_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
            assign expired = enable && (r_count == LAST);
        end else begin : g_timeout_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/split_reg.sv
`default_nettype none
// ============================================================================
// Module      : split_reg
// Description : Registered 1-to-N native-bus splitter with per-transaction
//               timeout, decode-error response and sticky error flag.
// Revision    : 1.0
// ============================================================================
module split_reg
    import split_reg_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int P_SLAVES = ADDR_W - 2,
    parameter int TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA),
    localparam int SEL_W  = sel_width(N_SLAVES),
    localparam int REQ_W  = req_width(ADDR_W, DATA_W),
    localparam int RESP_W = resp_width(DATA_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_W-1:0]             m_req,
    output logic [RESP_W-1:0]            m_resp,
    output logic [N_SLAVES*REQ_W-1:0]    s_req,
    input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
    output logic                         err,
    output logic [SEL_W-1:0]             err_sel,
    input  logic                         err_clr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int N_PAD  = 1 << SEL_W;

    logic                w_m_valid;
    logic [ADDR_W-1:0]   w_m_addr;
    logic [DATA_W-1:0]   w_m_wdata;
    logic [STRB_W-1:0]   w_m_wstrb;
    logic [SEL_W-1:0]    w_m_sel;
    logic                w_in_range;

    assign w_m_valid  = m_req[REQ_W-1];
    assign w_m_addr   = m_req[REQ_W-2 -: ADDR_W];
    assign w_m_wdata  = m_req[STRB_W +: DATA_W];
    assign w_m_wstrb  = m_req[0 +: STRB_W];
    assign w_m_sel    = w_m_addr[P_SLAVES -: SEL_W];
    assign w_in_range = (32'(w_m_sel) < N_SLAVES);

    state_e              r_state;
    logic                r_s_valid;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [RESP_W-1:0]   r_m_resp;
    logic                r_err;
    logic [SEL_W-1:0]    r_err_sel;

    // Unused select codes map to padding slots that never answer.
    logic [N_PAD-1:0]    w_slv_ready;
    logic [DATA_W-1:0]   w_slv_rdata [N_PAD];
    logic                w_sel_ready;
    logic [DATA_W-1:0]   w_sel_rdata;

    generate
        for (genvar i = 0; i < N_PAD; i++) begin : g_resp
            if (i < N_SLAVES) begin : g_real
                assign w_slv_ready[i] = s_resp[i*RESP_W];
                assign w_slv_rdata[i] = s_resp[i*RESP_W + 1 +: DATA_W];
            end else begin : g_pad
                assign w_slv_ready[i] = 1'b0;
                assign w_slv_rdata[i] = '0;
            end
        end
    endgenerate

    assign w_sel_ready = w_slv_ready[r_sel];
    assign w_sel_rdata = w_slv_rdata[r_sel];

    logic [REQ_W-1:0] w_req_word;
    assign w_req_word = {r_s_valid, r_addr, r_wdata, r_wstrb};

    generate
        for (genvar i = 0; i < N_SLAVES; i++) begin : g_sreq
            assign s_req[i*REQ_W +: REQ_W] =
                (r_s_valid && (r_sel == SEL_W'(i))) ? w_req_word : '0;
        end
    endgenerate

    logic w_tmr_clear;
    logic w_tmr_en;
    logic w_expired;

    assign w_tmr_clear = (r_state != ST_WAIT);
    assign w_tmr_en    = (r_state == ST_WAIT) && !w_sel_ready;

    split_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_s_valid <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_m_resp  <= '0;
            r_err     <= 1'b0;
            r_err_sel <= '0;
        end else begin
            r_m_resp <= '0;
            // A new error later in this block overrides the clear.
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_m_valid) begin
                        if (w_in_range) begin
                            r_sel     <= w_m_sel;
                            r_addr    <= w_m_addr;
                            r_wdata   <= w_m_wdata;
                            r_wstrb   <= w_m_wstrb;
                            r_s_valid <= 1'b1;
                            r_state   <= ST_WAIT;
                        end else begin
                            r_m_resp  <= {ERR_DATA, 1'b1};
                            r_err     <= 1'b1;
                            r_err_sel <= w_m_sel;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_sel_ready) begin
                        r_s_valid <= 1'b0;
                        r_m_resp  <= {w_sel_rdata, 1'b1};
                        r_state   <= ST_RESP;
                    end else if (w_expired) begin
                        r_s_valid <= 1'b0;
                        r_m_resp  <= {ERR_DATA, 1'b1};
                        r_err     <= 1'b1;
                        r_err_sel <= r_sel;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_resp  = r_m_resp;
    assign err     = r_err;
    assign err_sel = r_err_sel;

endmodule
`default_nettype wire

// File: tb/tb_split_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_reg
// Description : Self-checking bench for split_reg (3 slaves, timeout of 8).
// Revision    : 1.0
// ============================================================================
module tb_split_reg;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int N      = 3;
    localparam int PS     = 30;
    localparam int T      = 8;
    localparam int SW     = 2;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;
    localparam int MAXC   = 16384;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  err_clr = 1'b0;
    logic                  err;
    logic [SW-1:0]         err_sel;
    logic [REQ_W-1:0]      m_req = '0;
    logic [RESP_W-1:0]     m_resp;
    logic [N*REQ_W-1:0]    s_req;
    logic [N*RESP_W-1:0]   s_resp = '0;

    split_reg #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .N_SLAVES (N),
        .P_SLAVES (PS),
        .TIMEOUT  (T),
        .ERR_DATA (ERRW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .err     (err),
        .err_sel (err_sel),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    // Expected-output timeline, indexed by cycle number.
    bit [N*REQ_W-1:0]  exp_sreq  [MAXC];
    bit [RESP_W-1:0]   exp_mresp [MAXC];
    bit                exp_eset  [MAXC];
    bit [SW-1:0]       exp_esel  [MAXC];

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            m_err = 1'b0;
    bit [SW-1:0]   m_esel = '0;
    int            ready_cnt = 0;
    int            sv_cnt = 0;
    logic [DW-1:0] last_rdata = '0;
    int            last_ready_cyc = 0;
    bit            rand_clr = 1'b0;
    int            t_c0 = 0;

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (cyc >= MAXC) begin
                errors++;
                $display("FAIL cycle_budget cyc=%0d got=over want=under", cyc);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "cycle budget exceeded");
            end
            if (rst) begin
                m_err  = 1'b0;
                m_esel = '0;
            end else if (exp_eset[cyc]) begin
                m_err  = 1'b1;
                m_esel = exp_esel[cyc];
            end else if (err_clr) begin
                m_err = 1'b0;
            end
            @(negedge clk);
            cmp("s_req",   256'(s_req),   256'(exp_sreq[cyc]));
            cmp("m_resp",  256'(m_resp),  256'(exp_mresp[cyc]));
            cmp("err",     256'(err),     256'(m_err));
            cmp("err_sel", 256'(err_sel), 256'(m_esel));
            if (m_resp[0] === 1'b1) begin
                ready_cnt++;
                last_rdata     = m_resp[DW:1];
                last_ready_cyc = cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (s_req[i*REQ_W + REQ_W - 1] === 1'b1) sv_cnt++;
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        logic [N*RESP_W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*RESP_W +: RESP_W] = {32'($urandom), 1'($urandom_range(0, 1))};
        end
        s_resp  = v;
        err_clr = rand_clr && ($urandom_range(0, 7) == 0);
        next_cycle();
    endtask

    // One master transaction; the slave answers d cycles after its valid
    // rises (d >= T never answers). rst_at > 0 resets during the transaction.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] rdv,
                       input int d, input int rst_at, input bit clr0);
        int c0;
        int nv;
        int r;
        int sel;
        bit ok;
        bit hit;
        logic [REQ_W-1:0]    word;
        logic [N*RESP_W-1:0] v;
        c0   = cyc;
        t_c0 = c0;
        sel  = int'(addr[PS -: SW]);
        word = {1'b1, addr, wdata, wstrb};
        ok   = (sel < N);
        hit  = ok && (d < T);
        nv   = !ok ? 0 : (hit ? d + 1 : T);
        r    = c0 + nv + 1;
        for (int k = 1; k <= nv; k++) exp_sreq[c0+k][sel*REQ_W +: REQ_W] = word;
        exp_mresp[r] = {hit ? rdv : ERRW, 1'b1};
        if (!hit) begin
            exp_eset[r] = 1'b1;
            exp_esel[r] = addr[PS -: SW];
        end
        m_req = word;
        for (int c = c0; c <= r; c++) begin
            v = '0;
            for (int i = 0; i < N; i++) begin
                if (i != sel || c == c0 || c == r)
                    v[i*RESP_W +: RESP_W] = {32'($urandom), 1'($urandom_range(0, 1))};
            end
            if (hit && c == c0 + 1 + d) v[sel*RESP_W +: RESP_W] = {rdv, 1'b1};
            s_resp  = v;
            err_clr = (clr0 && c == c0) || (rand_clr && $urandom_range(0, 7) == 0);
            if (rst_at > 0 && c == c0 + rst_at) begin
                rst = 1'b1;
                for (int k = c + 1; k <= r; k++) begin
                    exp_sreq[k]  = '0;
                    exp_mresp[k] = '0;
                    exp_eset[k]  = 1'b0;
                end
                next_cycle();
                rst     = 1'b0;
                m_req   = '0;
                s_resp  = '0;
                err_clr = 1'b0;
                return;
            end
            next_cycle();
        end
        m_req = REQ_W'({$urandom, $urandom, $urandom});
        m_req[REQ_W-1] = 1'b0;
        repeat (1 + $urandom_range(0, 2)) idle_cycle();
    endtask

    int r0;
    int sv0;

    initial begin
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_m_resp",  256'(m_resp),  256'(0));
        cmp("rst_s_req",   256'(s_req),   256'(0));
        cmp("rst_err",     256'(err),     256'(0));
        cmp("rst_err_sel", 256'(err_sel), 256'(0));
        next_cycle();

        // Read from slave 1, ready two cycles after its valid.
        r0 = ready_cnt;
        txn(32'h2000_0010, 32'h0, 4'h0, 32'h1234_5678, 2, 0, 1'b0);
        cmp("rd_rdata", 256'(last_rdata), 256'(32'h1234_5678));
        cmp("rd_lat",   256'(last_ready_cyc - t_c0), 256'(4));
        cmp("rd_once",  256'(ready_cnt - r0), 256'(1));
        cmp("rd_err",   256'(err), 256'(0));

        // Write to slave 2, ready in the same cycle as its valid.
        txn(32'h4000_0000, 32'hCAFE_0001, 4'hF, 32'h5555_AAAA, 0, 0, 1'b0);
        cmp("wr_lat", 256'(last_ready_cyc - t_c0), 256'(2));

        // Unmapped select.
        sv0 = sv_cnt;
        txn(32'h6000_0000, 32'h0, 4'h0, 32'h0, 0, 0, 1'b0);
        cmp("dec_rdata", 256'(last_rdata), 256'(32'hDEAD_BEEF));
        cmp("dec_lat",   256'(last_ready_cyc - t_c0), 256'(1));
        cmp("dec_nosv",  256'(sv_cnt - sv0), 256'(0));
        cmp("dec_err",   256'(err), 256'(1));
        cmp("dec_sel",   256'(err_sel), 256'(3));
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        cmp("clr_err", 256'(err), 256'(0));
        cmp("clr_sel", 256'(err_sel), 256'(3));

        // Slave 2 never answers.
        sv0 = sv_cnt;
        txn(32'h4000_0000, 32'h0, 4'h0, 32'h0, 100, 0, 1'b0);
        cmp("to_svcnt", 256'(sv_cnt - sv0), 256'(8));
        cmp("to_rdata", 256'(last_rdata), 256'(32'hDEAD_BEEF));
        cmp("to_lat",   256'(last_ready_cyc - t_c0), 256'(9));
        cmp("to_err",   256'(err), 256'(1));
        cmp("to_sel",   256'(err_sel), 256'(2));
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        cmp("to_clr", 256'(err), 256'(0));

        // Ready in the last WAIT cycle beats the timeout.
        txn(32'h0000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 7, 0, 1'b0);
        cmp("late_rdata", 256'(last_rdata), 256'(32'h0BAD_F00D));
        cmp("late_err",   256'(err), 256'(0));

        // Clear and new error in the same cycle.
        txn(32'h6000_0004, 32'h0, 4'h0, 32'h0, 0, 0, 1'b1);
        cmp("setwin_err", 256'(err), 256'(1));

        // Reset during WAIT, then a fresh transaction.
        txn(32'h2000_0000, 32'h0, 4'h0, 32'h0, 100, 3, 1'b0);
        @(negedge clk);
        cmp("mid_m_resp", 256'(m_resp), 256'(0));
        cmp("mid_s_req",  256'(s_req),  256'(0));
        cmp("mid_err",    256'(err),    256'(0));
        next_cycle();
        txn(32'h2000_0008, 32'h0, 4'h0, 32'h7777_0001, 1, 0, 1'b0);
        cmp("post_rdata", 256'(last_rdata), 256'(32'h7777_0001));
        cmp("post_lat",   256'(last_ready_cyc - t_c0), 256'(3));

        // Randomized traffic with random error clears.
        rand_clr = 1'b1;
        for (int n = 0; n < 300; n++) begin
            txn($urandom, $urandom, 4'($urandom), $urandom, $urandom_range(0, 10), 0, 1'b0);
        end
        rand_clr = 1'b0;
        err_clr  = 1'b0;
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
